reduce_nway_pipe: RTL and testbench

//   Parametrised, pipelined N-way bit reduction: reduces a WIDTH-bit word to one bit

---
 rtl/reduce_nway_pipe.sv | 123 ++++++++++++
 tb/tb_reduce_nway_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_nway_pipe.sv
// Pipelined N-way bit reduction (OR/AND/XOR/NOR) with valid/ready handshakes,
// a sticky OR accumulator of delivered results and a wrapping result counter.
module reduce_nway_pipe #(
  parameter int WIDTH = 16,
  parameter bit PIPE  = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             acc,
  input  logic             acc_clr,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int D = $clog2(WIDTH);
  localparam int P = 1 << D;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  logic         en;
  logic         deliver;
  logic [P-1:0] leaves;

  // Pad unused leaves with the identity of the selected op.
  always_comb begin
    leaves              = {P{op == OP_AND}};
    leaves[WIDTH-1:0]   = in;
  end

  genvar k;
  for (k = 1; k <= D; k++) begin : g_lvl
    localparam int N = 1 << (D - k);

    logic [2*N-1:0] src_d;
    op_e            src_op;
    logic           src_v;
    logic [N-1:0]   nxt_d;
    logic [N-1:0]   q_d;
    op_e            q_op;
    logic           q_v;

    if (k == 1) begin : g_src_in
      assign src_d  = leaves;
      assign src_op = op_e'(op);
      assign src_v  = in_valid;
    end else begin : g_src_lvl
      assign src_d  = g_lvl[k-1].q_d;
      assign src_op = g_lvl[k-1].q_op;
      assign src_v  = g_lvl[k-1].q_v;
    end

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
      nxt_d = '0;
      for (int i = 0; i < N; i++) begin
        case (src_op)
          OP_AND:  nxt_d[i] = src_d[2*i] & src_d[2*i+1];
          OP_XOR:  nxt_d[i] = src_d[2*i] ^ src_d[2*i+1];
          default: nxt_d[i] = src_d[2*i] | src_d[2*i+1];
        endcase
      end
    end

    if (PIPE || k == D) begin : g_reg
      // NOTE: only valid bits (and the visible output stage) are reset; interior
      // data/op registers are qualified by their valid bit, so reset is not needed.
      // Sequential state uses non-blocking assignments so all stages update together.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_v <= 1'b0;
          if (k == D) begin
            q_d  <= '0;
            q_op <= OP_OR;
          end
        end else if (en) begin
          q_v <= src_v;
          if (src_v) begin
            q_d  <= nxt_d;
            q_op <= src_op;
          end
        end
      end
    end else begin : g_wire
      assign q_d  = nxt_d;
      assign q_op = src_op;
      assign q_v  = src_v;
    end
  end

  // NOR travels through the tree as OR and is inverted at the output.
  assign out_valid = g_lvl[D].q_v;
  assign out       = g_lvl[D].q_d[0] ^ (g_lvl[D].q_op == OP_NOR);

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign deliver  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= 1'b0;
      out_cnt <= '0;
    end else if (deliver) begin
      acc     <= (acc_clr ? 1'b0 : acc) | out;
      out_cnt <= out_cnt + 1'b1;
    end else if (acc_clr) begin
      acc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Directed and random checks of reduce_nway_pipe across four configurations:
// WIDTH 8/5 crossed with PIPE 1/0, all with a 2-bit result counter.
module tb_reduce_nway_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_a        [4];
  logic [1:0] op_a        [4];
  logic       in_valid_a  [4];
  logic       in_ready_a  [4];
  logic       out_a       [4];
  logic       out_valid_a [4];
  logic       out_ready_a [4];
  logic       acc_a       [4];
  logic       acc_clr_a   [4];
  logic [1:0] cnt_a       [4];

  int checks = 0;
  int errors = 0;
  int lat_exp [4] = '{3, 1, 3, 1};
  int wid     [4] = '{8, 8, 5, 5};

  reduce_nway_pipe #(.WIDTH(8), .PIPE(1'b1), .CNT_W(2)) u_w8_p1 (
    .clk(clk), .rst_n(rst_n), .in(in_a[0]), .op(op_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .out(out_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .acc(acc_a[0]), .acc_clr(acc_clr_a[0]), .out_cnt(cnt_a[0]));
  reduce_nway_pipe #(.WIDTH(8), .PIPE(1'b0), .CNT_W(2)) u_w8_p0 (
    .clk(clk), .rst_n(rst_n), .in(in_a[1]), .op(op_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .out(out_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .acc(acc_a[1]), .acc_clr(acc_clr_a[1]), .out_cnt(cnt_a[1]));
  reduce_nway_pipe #(.WIDTH(5), .PIPE(1'b1), .CNT_W(2)) u_w5_p1 (
    .clk(clk), .rst_n(rst_n), .in(in_a[2][4:0]), .op(op_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .out(out_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .acc(acc_a[2]), .acc_clr(acc_clr_a[2]), .out_cnt(cnt_a[2]));
  reduce_nway_pipe #(.WIDTH(5), .PIPE(1'b0), .CNT_W(2)) u_w5_p0 (
    .clk(clk), .rst_n(rst_n), .in(in_a[3][4:0]), .op(op_a[3]), .in_valid(in_valid_a[3]),
    .in_ready(in_ready_a[3]), .out(out_a[3]), .out_valid(out_valid_a[3]),
    .out_ready(out_ready_a[3]), .acc(acc_a[3]), .acc_clr(acc_clr_a[3]), .out_cnt(cnt_a[3]));

  typedef struct {
    logic [7:0] w;
    logic [1:0] o;
    logic       e8;
    logic       e5;
  } vec_t;

  vec_t       vt   [13];
  logic [7:0] s_w  [6];
  logic [1:0] s_o  [6];
  logic       s_e  [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_red(input logic [7:0] w, input logic [1:0] o, input int width);
    logic r;
    r = (o == 2'b01);
    for (int i = 0; i < width; i++) begin
      case (o)
        2'b01:   r = r & w[i];
        2'b10:   r = r ^ w[i];
        default: r = r | w[i];
      endcase
    end
    if (o == 2'b11) r = ~r;
    return r;
  endfunction

  // Single word: hold the result with out_ready=0, then deliver it (optionally with acc_clr).
  task automatic xact(input int d, input logic [7:0] w, input logic [1:0] o, input logic clr,
                      output logic res, output int lat);
    out_ready_a[d] = 1'b0;
    in_a[d]        = w;
    op_a[d]        = o;
    in_valid_a[d]  = 1'b1;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    lat = 1;
    while (!out_valid_a[d] && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    res            = out_a[d];
    acc_clr_a[d]   = clr;
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    acc_clr_a[d] = 1'b0;
  endtask

  // Stream n words; directed mode stalls the consumer for cycles 4..6.
  task automatic stream(input int d, input int n, input bit rnd);
    logic [7:0] w [64];
    logic [1:0] o [64];
    logic       e [64];
    logic       exp_q [$];
    int         tx = 0, rx = 0, cyc = 0;
    bit         held = 1'b0;
    logic       held_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        w[i] = 8'($urandom);
        o[i] = 2'($urandom);
        e[i] = ref_red(w[i], o[i], wid[d]);
      end else begin
        w[i] = s_w[i];
        o[i] = s_o[i];
        e[i] = s_e[i];
      end
    end
    while (rx < n && cyc < 300) begin
      if (tx < n) begin
        in_a[d]       = w[tx];
        op_a[d]       = o[tx];
        in_valid_a[d] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        in_valid_a[d] = 1'b0;
      end
      out_ready_a[d] = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (held) begin
        check($sformatf("hold_valid d%0d", d), out_valid_a[d], 1);
        check($sformatf("hold_out d%0d", d), out_a[d], held_v);
      end
      held   = out_valid_a[d] && !out_ready_a[d];
      held_v = out_a[d];
      if (held) check($sformatf("stall_in_ready d%0d", d), in_ready_a[d], 0);
      if (out_valid_a[d] && out_ready_a[d]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_result d%0d: got result %0d with nothing outstanding", d, out_a[d]);
        end else begin
          check($sformatf("stream d%0d #%0d", d, rx), out_a[d], exp_q.pop_front());
        end
        rx++;
      end
      if (in_valid_a[d] && in_ready_a[d]) begin
        exp_q.push_back(e[tx]);
        tx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_a[d]  = 1'b0;
    out_ready_a[d] = 1'b1;
    check($sformatf("delivered d%0d", d), rx, n);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check($sformatf("drained d%0d", d), out_valid_a[d], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic res;
    int   lat;
    bit   seen;

    vt[0]  = '{8'h00, 2'b00, 1'b0, 1'b0};
    vt[1]  = '{8'h10, 2'b00, 1'b1, 1'b1};
    vt[2]  = '{8'h1F, 2'b01, 1'b0, 1'b1};
    vt[3]  = '{8'h1E, 2'b01, 1'b0, 1'b0};
    vt[4]  = '{8'hFF, 2'b01, 1'b1, 1'b1};
    vt[5]  = '{8'hA5, 2'b10, 1'b0, 1'b0};
    vt[6]  = '{8'hA4, 2'b10, 1'b1, 1'b1};
    vt[7]  = '{8'h00, 2'b11, 1'b1, 1'b1};
    vt[8]  = '{8'h01, 2'b11, 1'b0, 1'b0};
    vt[9]  = '{8'hE0, 2'b11, 1'b0, 1'b1};
    vt[10] = '{8'hE0, 2'b01, 1'b0, 1'b0};
    vt[11] = '{8'h1F, 2'b10, 1'b1, 1'b1};
    vt[12] = '{8'h0F, 2'b10, 1'b0, 1'b0};

    s_w = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h03, 8'h00};
    s_o = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    s_e = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      in_a[d]        = '0;
      op_a[d]        = '0;
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b1;
      acc_clr_a[d]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst out_valid d%0d", d), out_valid_a[d], 0);
      check($sformatf("rst out d%0d", d), out_a[d], 0);
      check($sformatf("rst acc d%0d", d), acc_a[d], 0);
      check($sformatf("rst out_cnt d%0d", d), cnt_a[d], 0);
      check($sformatf("rst in_ready d%0d", d), in_ready_a[d], 1);
    end

    // Function and latency for every op, including identity padding on WIDTH=5.
    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 13; v++) begin
        xact(d, vt[v].w, vt[v].o, 1'b0, res, lat);
        check($sformatf("vec d%0d #%0d", d, v), res, (d < 2) ? vt[v].e8 : vt[v].e5);
        check($sformatf("lat d%0d #%0d", d, v), lat, lat_exp[d]);
      end
    end

    stream(0, 6, 1'b0);
    stream(1, 6, 1'b0);

    // Accumulator and wrapping counter.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      xact(d, 8'h00, 2'b00, 1'b0, res, lat);
      xact(d, 8'h80, 2'b00, 1'b0, res, lat);
      xact(d, 8'h00, 2'b00, 1'b0, res, lat);
      check($sformatf("acc after 0,1,0 d%0d", d), acc_a[d], 1);
      check($sformatf("cnt after 3 d%0d", d), cnt_a[d], 3);
      xact(d, 8'h00, 2'b00, 1'b1, res, lat);
      check($sformatf("acc clr+deliver0 d%0d", d), acc_a[d], 0);
      check($sformatf("cnt wrap d%0d", d), cnt_a[d], 0);
      xact(d, 8'h80, 2'b00, 1'b0, res, lat);
      check($sformatf("acc after 1 d%0d", d), acc_a[d], 1);
      acc_clr_a[d] = 1'b1;
      @(posedge clk); #1;
      acc_clr_a[d] = 1'b0;
      check($sformatf("acc clr alone d%0d", d), acc_a[d], 0);
      check($sformatf("cnt clr alone d%0d", d), cnt_a[d], 1);
      xact(d, 8'h80, 2'b00, 1'b1, res, lat);
      check($sformatf("acc clr+deliver1 d%0d", d), acc_a[d], 1);
      check($sformatf("cnt after clr+deliver1 d%0d", d), cnt_a[d], 2);
    end

    // Reset with words in flight discards them.
    for (int d = 0; d < 4; d++) xact(d, 8'h80, 2'b00, 1'b0, res, lat);
    for (int d = 0; d < 4; d++) begin
      in_a[d]        = 8'h80;
      op_a[d]        = 2'b00;
      in_valid_a[d]  = 1'b1;
      out_ready_a[d] = 1'b0;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int d = 0; d < 4; d++) in_valid_a[d] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("flight rst out_valid d%0d", d), out_valid_a[d], 0);
      check($sformatf("flight rst acc d%0d", d), acc_a[d], 0);
      check($sformatf("flight rst out_cnt d%0d", d), cnt_a[d], 0);
    end
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) out_ready_a[d] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (out_valid_a[d]) seen = 1'b1;
        if (d == 3 && c < 5) begin
          @(posedge clk); #1;
        end
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 4; d++) if (out_valid_a[d]) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("no stale result after reset", seen, 0);

    for (int d = 0; d < 4; d++) stream(d, 40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
